// File: rtl/loop_iter_ctrl.sv
// Nested-loop iteration engine: captures per-level iteration counts and walks them innermost-fastest,
// emitting one handshaked beat per innermost iteration. Optional iter_index output: LOOP_CTRL_IDX_OUT_EN.
module loop_iter_ctrl #(
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16,
  parameter int MAX_LOOPS   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0]       cfg_loop_iter,
  input  logic [LOOP_ID_W-1:0]         cfg_loop_iter_loop_id,
  input  logic                         loop_ctrl_start,
  output logic                         loop_ctrl_done,
  output logic                         iter_v,
  input  logic                         iter_ready,
  output logic                         iter_first,
  output logic                         iter_last,
  output logic [LOOP_ID_W-1:0]         iter_level,
`ifdef LOOP_CTRL_IDX_OUT_EN
  output logic [MAX_LOOPS*LOOP_ITER_W-1:0] iter_index,
`endif
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int DEPTH_W = $clog2(MAX_LOOPS + 1);
  localparam int IDX_W   = (MAX_LOOPS > 1) ? $clog2(MAX_LOOPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [LOOP_ITER_W-1:0] r_iter [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0] r_cnt  [MAX_LOOPS];
  logic [DEPTH_W-1:0]     r_depth;
  logic                   r_done;
  logic                   r_iter_v;
  logic                   r_first;
  logic                   r_last;
  logic [LOOP_ID_W-1:0]   r_level;
  logic                   r_busy;
  logic                   r_cfg_err;

  logic                   w_cfg_ok;
  logic [IDX_W-1:0]       w_id_idx;
  logic [DEPTH_W-1:0]     w_id_depth;
  logic [LOOP_ITER_W-1:0] w_iter_wr [MAX_LOOPS];
  logic [DEPTH_W-1:0]     w_depth_wr;
  logic [LOOP_ID_W-1:0]   w_lvl;
  logic [LOOP_ITER_W-1:0] w_cnt_step [MAX_LOOPS];
  logic                   w_last_step;
  logic                   w_last_start;

  assign w_id_idx   = cfg_loop_iter_loop_id[IDX_W-1:0];
  assign w_id_depth = DEPTH_W'(cfg_loop_iter_loop_id) + DEPTH_W'(1);

  // Config write merge and next-beat stepping; the start beat sees a same-cycle cfg write
  always_comb begin
    w_cfg_ok   = cfg_loop_iter_v && (r_state == S_IDLE) &&
                 (32'(cfg_loop_iter_loop_id) < 32'(MAX_LOOPS));
    w_iter_wr  = r_iter;
    w_depth_wr = r_depth;
    if (w_cfg_ok) begin
      w_iter_wr[w_id_idx] = cfg_loop_iter;
      if (w_id_depth > r_depth) begin
        w_depth_wr = w_id_depth;
      end else begin
        w_depth_wr = r_depth;
      end
    end else begin
      w_depth_wr = r_depth;
    end

    w_lvl = {LOOP_ID_W{1'b0}};
    for (int k = 0; k < MAX_LOOPS; k++) begin
      if ((DEPTH_W'(k) < r_depth) && (r_cnt[k] != r_iter[k])) begin
        w_lvl = LOOP_ID_W'(k);
      end else begin
        w_lvl = w_lvl;
      end
    end

    w_last_step  = 1'b1;
    w_last_start = 1'b1;
    for (int k = 0; k < MAX_LOOPS; k++) begin
      if (LOOP_ID_W'(k) == w_lvl) begin
        w_cnt_step[k] = r_cnt[k] + LOOP_ITER_W'(1);
      end else if (LOOP_ID_W'(k) > w_lvl) begin
        w_cnt_step[k] = {LOOP_ITER_W{1'b0}};
      end else begin
        w_cnt_step[k] = r_cnt[k];
      end
      if ((DEPTH_W'(k) < r_depth) && (w_cnt_step[k] != r_iter[k])) begin
        w_last_step = 1'b0;
      end else begin
        w_last_step = w_last_step;
      end
      if ((DEPTH_W'(k) < w_depth_wr) && (w_iter_wr[k] != {LOOP_ITER_W{1'b0}})) begin
        w_last_start = 1'b0;
      end else begin
        w_last_start = w_last_start;
      end
    end
  end

`ifdef LOOP_CTRL_IDX_OUT_EN
  logic [MAX_LOOPS*LOOP_ITER_W-1:0] r_index;
  logic [MAX_LOOPS*LOOP_ITER_W-1:0] w_idx_step;

  // Index of the next beat, masked to the configured depth
  always_comb begin
    w_idx_step = {(MAX_LOOPS*LOOP_ITER_W){1'b0}};
    for (int k = 0; k < MAX_LOOPS; k++) begin
      if (DEPTH_W'(k) < r_depth) begin
        w_idx_step[k*LOOP_ITER_W +: LOOP_ITER_W] = w_cnt_step[k];
      end else begin
        w_idx_step[k*LOOP_ITER_W +: LOOP_ITER_W] = {LOOP_ITER_W{1'b0}};
      end
    end
  end

  // Index register follows the beat and is zero outside RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= {(MAX_LOOPS*LOOP_ITER_W){1'b0}};
    end else if (r_state == S_RUN && iter_ready) begin
      r_index <= r_last ? {(MAX_LOOPS*LOOP_ITER_W){1'b0}} : w_idx_step;
    end else if (r_state != S_RUN) begin
      r_index <= {(MAX_LOOPS*LOOP_ITER_W){1'b0}};
    end
  end

  assign iter_index = r_index;
`endif

  // Main FSM with registered beat/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_depth   <= {DEPTH_W{1'b0}};
      r_done    <= 1'b0;
      r_iter_v  <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_level   <= {LOOP_ID_W{1'b0}};
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int k = 0; k < MAX_LOOPS; k++) begin
        r_iter[k] <= {LOOP_ITER_W{1'b0}};
        r_cnt[k]  <= {LOOP_ITER_W{1'b0}};
      end
    end else begin
      if (cfg_loop_iter_v && !w_cfg_ok) begin
        r_cfg_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_iter  <= w_iter_wr;
          r_depth <= w_depth_wr;
          if (loop_ctrl_start) begin
            r_state  <= S_RUN;
            r_iter_v <= 1'b1;
            r_first  <= 1'b1;
            r_last   <= w_last_start;
            r_level  <= {LOOP_ID_W{1'b0}};
            r_busy   <= 1'b1;
            for (int k = 0; k < MAX_LOOPS; k++) begin
              r_cnt[k] <= {LOOP_ITER_W{1'b0}};
            end
          end
        end
        S_RUN: begin
          if (iter_ready) begin
            if (r_last) begin
              r_state  <= S_DONE;
              r_iter_v <= 1'b0;
              r_first  <= 1'b0;
              r_last   <= 1'b0;
              r_level  <= {LOOP_ID_W{1'b0}};
              r_done   <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_step;
              r_first <= 1'b0;
              r_last  <= w_last_step;
              r_level <= w_lvl;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_depth <= {DEPTH_W{1'b0}};
          for (int k = 0; k < MAX_LOOPS; k++) begin
            r_iter[k] <= {LOOP_ITER_W{1'b0}};
            r_cnt[k]  <= {LOOP_ITER_W{1'b0}};
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_iter_v <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign loop_ctrl_done = r_done;
  assign iter_v         = r_iter_v;
  assign iter_first     = r_first;
  assign iter_last      = r_last;
  assign iter_level     = r_level;
  assign busy           = r_busy;
  assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_loop_iter_ctrl.sv
// Scoreboard bench for loop_iter_ctrl: directed runs push expected beats, a negedge monitor pops on accept.
module tb_loop_iter_ctrl;

  localparam int IW = 8 * 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_v = 1'b0;
  logic [15:0] cfg_val = 16'd0;
  logic [4:0]  cfg_id = 5'd0;
  logic        start = 1'b0;
  logic        done;
  logic        iter_v;
  logic        iter_ready = 1'b1;
  logic        iter_first;
  logic        iter_last;
  logic [4:0]  iter_level;
  logic        busy;
  logic        cfg_err;
  logic [IW-1:0] act_idx;

  loop_iter_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .cfg_loop_iter_v       (cfg_v),
    .cfg_loop_iter         (cfg_val),
    .cfg_loop_iter_loop_id (cfg_id),
    .loop_ctrl_start       (start),
    .loop_ctrl_done        (done),
    .iter_v                (iter_v),
    .iter_ready            (iter_ready),
    .iter_first            (iter_first),
    .iter_last             (iter_last),
    .iter_level            (iter_level),
`ifdef LOOP_CTRL_IDX_OUT_EN
    .iter_index            (act_idx),
`endif
    .busy                  (busy),
    .cfg_err               (cfg_err)
  );

`ifndef LOOP_CTRL_IDX_OUT_EN
  assign act_idx = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic          first;
    logic          last;
    logic [4:0]    level;
    logic [IW-1:0] idx;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic f, input logic l, input logic [4:0] lvl, input logic [IW-1:0] idx);
    beat_t b;
    b.first = f; b.last = l; b.level = lvl; b.idx = idx;
    q.push_back(b);
  endtask

  // Monitor: compares accepted beats, stall stability and done timing
  logic  exp_done = 1'b0;
  logic  held_v = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
      held_v   = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", IW'(done), IW'(exp_done));
      exp_done = 1'b0;
      if (held_v && iter_v) begin
        chk("stall_first", IW'(iter_first), IW'(held.first));
        chk("stall_last", IW'(iter_last), IW'(held.last));
        chk("stall_level", IW'(iter_level), IW'(held.level));
      end
      held_v = 1'b0;
      if (iter_v && iter_ready) begin
        if (q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL extra_beat: got beat with no expected entry");
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_first", IW'(iter_first), IW'(e.first));
          chk("beat_last", IW'(iter_last), IW'(e.last));
          chk("beat_level", IW'(iter_level), IW'(e.level));
`ifdef LOOP_CTRL_IDX_OUT_EN
          chk("beat_index", act_idx, e.idx);
`endif
          exp_done = e.last;
        end
      end else if (iter_v) begin
        held_v = 1'b1;
        held.first = iter_first; held.last = iter_last; held.level = iter_level;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; cfg_v = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] id, input logic [15:0] val);
    @(posedge clk); #1 cfg_v = 1'b1; cfg_id = id; cfg_val = val;
    @(posedge clk); #1 cfg_v = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input logic toggle);
    int n = 0;
    while (busy || q.size() != 0) begin
      if (n >= budget) begin
        failures++;
        checks++;
        $display("FAIL timeout: busy=%0d pending=%0d", busy, q.size());
        q.delete();
        break;
      end
      @(posedge clk); #1;
      if (toggle) iter_ready = ~iter_ready;
      n++;
    end
    iter_ready = 1'b1;
    chk("scoreboard_empty", IW'(q.size()), IW'(0));
  endtask

  // Expected beats for id0=1, id1=2: levels 0,1,1,0,1,1
  task automatic push_2x3();
    logic [4:0] lv [6];
    lv[0] = 5'd0; lv[1] = 5'd1; lv[2] = 5'd1; lv[3] = 5'd0; lv[4] = 5'd1; lv[5] = 5'd1;
    for (int i = 0; i < 6; i++) begin
      logic [IW-1:0] idx;
      idx = '0;
      idx[15:0]  = 16'(i / 3);
      idx[31:16] = 16'(i % 3);
      push(i == 0, i == 5, lv[i], idx);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_iter_v", IW'(iter_v), IW'(0));
    chk("rst_busy", IW'(busy), IW'(0));
    chk("rst_done", IW'(done), IW'(0));
    chk("rst_cfg_err", IW'(cfg_err), IW'(0));
    chk("rst_flags", IW'({iter_first, iter_last, iter_level}), IW'(0));
    chk("rst_index", act_idx, IW'(0));

    // 1: no config, single beat
    push(1'b1, 1'b1, 5'd0, '0);
    start_run();
    chk("t1_busy", IW'(busy), IW'(1));
    wait_idle(20, 1'b0);

    // 2: 2x3 nest, ready always high
    cfg_write(5'd0, 16'd1);
    cfg_write(5'd1, 16'd2);
    push_2x3();
    start_run();
    wait_idle(40, 1'b0);

    // 3: same nest, ready toggling
    cfg_write(5'd0, 16'd1);
    cfg_write(5'd1, 16'd2);
    push_2x3();
    start_run();
    iter_ready = 1'b0;
    wait_idle(60, 1'b1);
    chk("t3_cfg_err", IW'(cfg_err), IW'(0));

    // 4: cfg during RUN ignored, bad id ignored, cfg_err sticky
    cfg_write(5'd0, 16'd1);
    cfg_write(5'd1, 16'd2);
    push_2x3();
    start_run();
    cfg_write(5'd3, 16'd5);
    wait_idle(40, 1'b0);
    chk("t4_err_run", IW'(cfg_err), IW'(1));
    do_reset();
    chk("t4_err_clr", IW'(cfg_err), IW'(0));
    cfg_write(5'd9, 16'd3);
    chk("t4_err_id", IW'(cfg_err), IW'(1));
    push(1'b1, 1'b1, 5'd0, '0);
    start_run();
    wait_idle(20, 1'b0);
    chk("t4_err_hold", IW'(cfg_err), IW'(1));

    // 5: reset on beat 3
    do_reset();
    cfg_write(5'd0, 16'd1);
    cfg_write(5'd1, 16'd2);
    push(1'b1, 1'b0, 5'd0, '0);
    push(1'b0, 1'b0, 5'd1, IW'(32'h0001_0000));
    start_run();
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t5_iter_v", IW'(iter_v), IW'(0));
    chk("t5_busy", IW'(busy), IW'(0));
    chk("t5_pending", IW'(q.size()), IW'(0));
    q.delete();
    repeat (3) @(posedge clk);
    #1 push(1'b1, 1'b1, 5'd0, '0);
    start_run();
    wait_idle(20, 1'b0);

    // 6: 65536 beats on one level
    cfg_write(5'd0, 16'hFFFF);
    for (int i = 0; i < 65536; i++) begin
      logic [IW-1:0] idx;
      idx = '0;
      idx[15:0] = 16'(i);
      push(i == 0, i == 65535, 5'd0, idx);
    end
    start_run();
    wait_idle(70000, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("t6_busy_end", IW'(busy), IW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
